// File: rtl/mem_load_queue.sv
// In-order load/store completion queue between EX and WB.
// Memory ops wait for one dc_data_ok each, in issue order. Other ops are
// complete at enqueue. After a flush, responses still owed by the cache are
// absorbed by a discard counter before any later op can consume one.
module mem_load_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_alu_result,
  input  logic [31:0]           in_rt_value,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [6:0]            in_ls_type,
  input  logic [1:0]            in_offset,
  input  logic                  in_gr_we,
  input  logic [4:0]            in_dest,
  input  logic                  in_ex,
  input  logic                  dc_data_ok,
  input  logic [31:0]           dc_rdata,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_result,
  output logic                  out_gr_we,
  output logic [4:0]            out_dest,
  output logic                  out_ex,
  output logic [DEPTH-1:0]      byp_valid,
  output logic [5*DEPTH-1:0]    byp_dest,
  output logic [32*DEPTH-1:0]   byp_data,
  output logic                  spurious
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, outstanding, discard;

  // Entry control bits (reset) and payload (no reset).
  logic [DEPTH-1:0] e_valid, e_done;
  logic [DEPTH-1:0] e_gr_we, e_ex, e_load;
  logic [31:0]      e_pc     [DEPTH];
  logic [31:0]      e_result [DEPTH];
  logic [31:0]      e_rt     [DEPTH];
  logic [6:0]       e_type   [DEPTH];
  logic [1:0]       e_off    [DEPTH];
  logic [4:0]       e_dest   [DEPTH];

  logic enq, deq, mem_pend_in, dok_discard, dok_cmp;
  logic cmp_found;
  logic [PTR_W-1:0] cmp_idx, scan_idx;

  // Byte/halfword/word extraction and lwl/lwr merge with the old rt value.
  function automatic logic [31:0] load_extract(input logic [6:0]  t,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd,
                                               input logic [31:0] rt);
    logic [4:0]  sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] r;
    sh       = {off, 3'b000};
    byte_sel = 8'(rd >> sh);
    half_sel = 16'(rd >> {off[1], 4'b0000});
    r        = rd;
    if (t[6])      r = {{24{byte_sel[7]}}, byte_sel};
    else if (t[5]) r = {24'h0, byte_sel};
    else if (t[4]) r = {{16{half_sel[15]}}, half_sel};
    else if (t[3]) r = {16'h0, half_sel};
    else if (t[2]) r = rd;
    else if (t[1]) r = (rd << (5'd24 - sh)) | (rt & (32'h00FF_FFFF >> sh));
    else if (t[0]) r = (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
    return r;
  endfunction

  // Handshakes and response classification (discard first, then completion).
  assign out_valid   = (count != '0) & e_valid[head] & e_done[head];
  assign deq         = out_valid & out_ready;
  assign in_ready    = (count < CNT_W'(DEPTH)) | deq;
  assign enq         = in_valid & in_ready & ~flush;
  assign mem_pend_in = (in_is_load | in_is_store) & ~in_ex;
  assign dok_discard = dc_data_ok & (discard != '0);
  assign dok_cmp     = dc_data_ok & (discard == '0) & (outstanding != '0);

  assign out_pc     = e_pc[head];
  assign out_result = e_result[head];
  assign out_gr_we  = e_gr_we[head];
  assign out_dest   = e_dest[head];
  assign out_ex     = e_ex[head];

  // Oldest still-pending entry, scanning from head in queue order.
  always_comb begin
    cmp_found = 1'b0;
    cmp_idx   = head;
    scan_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (!cmp_found && e_valid[scan_idx] && !e_done[scan_idx]) begin
        cmp_found = 1'b1;
        cmp_idx   = scan_idx;
      end
    end
  end

  // Pointers, occupancy, response counters and entry status bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      e_valid     <= '0;
      e_done      <= '0;
      spurious    <= 1'b0;
    end else begin
      spurious <= dc_data_ok & (discard == '0) & (outstanding == '0);
      if (dok_cmp) e_done[cmp_idx] <= 1'b1;
      if (flush) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        e_valid     <= '0;
        outstanding <= '0;
        discard     <= discard - CNT_W'(dok_discard) + outstanding - CNT_W'(dok_cmp);
      end else begin
        if (deq) begin
          e_valid[head] <= 1'b0;
          head          <= head + PTR_W'(1);
        end
        // Enqueue after dequeue so a full-queue swap into the same slot wins.
        if (enq) begin
          e_valid[tail] <= 1'b1;
          e_done[tail]  <= ~mem_pend_in;
          tail          <= tail + PTR_W'(1);
        end
        count       <= count + CNT_W'(enq) - CNT_W'(deq);
        outstanding <= outstanding + CNT_W'(enq & mem_pend_in) - CNT_W'(dok_cmp);
        discard     <= discard - CNT_W'(dok_discard);
      end
    end
  end

  // Entry payload capture and result write-back on completion.
  always_ff @(posedge clk) begin
    if (enq) begin
      e_pc[tail]     <= in_pc;
      e_result[tail] <= in_alu_result;
      e_rt[tail]     <= in_rt_value;
      e_type[tail]   <= in_ls_type;
      e_off[tail]    <= in_offset;
      e_dest[tail]   <= in_dest;
      e_gr_we[tail]  <= in_gr_we;
      e_ex[tail]     <= in_ex;
      e_load[tail]   <= in_is_load;
    end
    if (dok_cmp && e_load[cmp_idx])
      e_result[cmp_idx] <= load_extract(e_type[cmp_idx], e_off[cmp_idx], dc_rdata, e_rt[cmp_idx]);
  end

  // Forwarding taps, one slice per physical entry.
  always_comb begin
    byp_valid = '0;
    byp_dest  = '0;
    byp_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_valid[i]        = e_valid[i] & e_gr_we[i] & e_done[i];
      byp_dest[5*i +: 5]  = e_dest[i];
      byp_data[32*i +: 32] = e_result[i];
    end
  end

endmodule

// File: tb/tb_mem_load_queue.sv
// Bench for mem_load_queue: directed cases for the extraction, full, flush and
// ordering behaviours, then randomized traffic against a queue-based model.
module tb_mem_load_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [31:0] in_pc, in_alu_result, in_rt_value;
  logic in_is_load, in_is_store;
  logic [6:0] in_ls_type;
  logic [1:0] in_offset;
  logic in_gr_we;
  logic [4:0] in_dest;
  logic in_ex;
  logic dc_data_ok;
  logic [31:0] dc_rdata;
  logic flush;
  logic out_valid, out_ready;
  logic [31:0] out_pc, out_result;
  logic out_gr_we;
  logic [4:0] out_dest;
  logic out_ex;
  logic [DEPTH-1:0] byp_valid;
  logic [5*DEPTH-1:0] byp_dest;
  logic [32*DEPTH-1:0] byp_data;
  logic spurious;

  always #5 clk = ~clk;

  mem_load_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_result(in_alu_result), .in_rt_value(in_rt_value),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_ls_type(in_ls_type), .in_offset(in_offset),
    .in_gr_we(in_gr_we), .in_dest(in_dest), .in_ex(in_ex),
    .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_gr_we(out_gr_we),
    .out_dest(out_dest), .out_ex(out_ex),
    .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_data(byp_data),
    .spurious(spurious)
  );

  typedef struct {
    logic [31:0] pc, result, rt;
    logic [6:0]  t;
    logic [1:0]  off;
    logic [4:0]  dest;
    logic        gr_we, ex, done, load;
  } ent_t;

  typedef struct {
    logic [31:0] pc, result;
    logic [4:0]  dest;
    logic        gr_we, ex;
  } exp_t;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } byp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  byp_t snap[$];
  int   m_disc;
  bit   m_spur_next;
  bit   cur_valid, cur_spur, mon_en;
  int   cur_size;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference extraction written byte-wise from the instruction semantics.
  function automatic logic [31:0] ref_load(input logic [6:0] t, input logic [1:0] off,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0] rb[4];
    logic [7:0] tb[4];
    logic [7:0] ob[4];
    logic [7:0] b;
    logic [15:0] h;
    int k;
    k = int'(off);
    for (int j = 0; j < 4; j++) begin
      rb[j] = rd[8*j +: 8];
      tb[j] = rt[8*j +: 8];
    end
    b = rb[k];
    h = {rb[2*int'(off[1]) + 1], rb[2*int'(off[1])]};
    if (t[6]) return {{24{b[7]}}, b};
    if (t[5]) return {24'h0, b};
    if (t[4]) return {{16{h[15]}}, h};
    if (t[3]) return {16'h0, h};
    if (t[2]) return rd;
    if (t[1]) begin
      for (int j = 0; j < 4; j++) ob[j] = (j >= 3 - k) ? rb[j - (3 - k)] : tb[j];
      return {ob[3], ob[2], ob[1], ob[0]};
    end
    if (t[0]) begin
      for (int j = 0; j < 4; j++) ob[j] = (j <= 3 - k) ? rb[j + k] : tb[j];
      return {ob[3], ob[2], ob[1], ob[0]};
    end
    return rd;
  endfunction

  function automatic int m_pending();
    int n;
    n = 0;
    foreach (mq[i]) if (!mq[i].done) n++;
    return n;
  endfunction

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_update();
    ent_t e;
    exp_t x;
    bit fire, rdy, found;
    fire = (mq.size() > 0) && mq[0].done && out_ready;
    rdy  = (mq.size() < DEPTH) || fire;
    if (fire) begin
      x.pc = mq[0].pc; x.result = mq[0].result; x.dest = mq[0].dest;
      x.gr_we = mq[0].gr_we; x.ex = mq[0].ex;
      exp_q.push_back(x);
      void'(mq.pop_front());
    end
    m_spur_next = 1'b0;
    if (dc_data_ok) begin
      if (m_disc > 0) m_disc--;
      else if (m_pending() > 0) begin
        found = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          if (!found && !mq[i].done) begin
            found = 1'b1;
            mq[i].done = 1'b1;
            if (mq[i].load) mq[i].result = ref_load(mq[i].t, mq[i].off, dc_rdata, mq[i].rt);
          end
        end
      end else m_spur_next = 1'b1;
    end
    if (flush) begin
      m_disc += m_pending();
      mq.delete();
    end else if (in_valid && rdy) begin
      e.pc = in_pc; e.result = in_alu_result; e.rt = in_rt_value;
      e.t = in_ls_type; e.off = in_offset; e.dest = in_dest;
      e.gr_we = in_gr_we; e.ex = in_ex; e.load = in_is_load;
      e.done = !((in_is_load || in_is_store) && !in_ex);
      mq.push_back(e);
    end
  endtask

  task automatic set_expect();
    byp_t s;
    cur_size  = mq.size();
    cur_valid = (mq.size() > 0) && mq[0].done;
    cur_spur  = m_spur_next;
    snap.delete();
    foreach (mq[i]) if (mq[i].done && mq[i].gr_we) begin
      s.dest = mq[i].dest; s.data = mq[i].result;
      snap.push_back(s);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    set_expect();
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_pc = '0; in_alu_result = '0; in_rt_value = '0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_ls_type = '0; in_offset = '0;
    in_gr_we = 1'b0; in_dest = '0; in_ex = 1'b0;
    dc_data_ok = 1'b0; dc_rdata = '0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rt,
                        input bit ld, input bit st, input logic [6:0] t, input logic [1:0] off,
                        input bit gw, input logic [4:0] dest, input bit ex);
    in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_rt_value = rt;
    in_is_load = ld; in_is_store = st; in_ls_type = t; in_offset = off;
    in_gr_we = gw; in_dest = dest; in_ex = ex;
  endtask

  task automatic load_case(input string name, input logic [6:0] t, input logic [1:0] off,
                           input logic [31:0] rd, input logic [31:0] rt, input logic [31:0] want);
    set_idle();
    set_op(32'h100, 32'h1000, rt, 1'b1, 1'b0, t, off, 1'b1, 5'd5, 1'b0);
    tick();
    set_idle();
    dc_data_ok = 1'b1;
    dc_rdata   = rd;
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk(name, out_result, want);
    set_idle();
    tick();
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each WB handshake.
  exp_t mon_x;
  int   mon_nb;
  bit   mon_found;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(cur_valid));
      chk("in_ready", 32'(in_ready), 32'((cur_size < DEPTH) || (cur_valid && out_ready)));
      chk("spurious", 32'(spurious), 32'(cur_spur));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out_fire: got dequeue of pc %h, wanted none", out_pc);
        end else begin
          mon_x = exp_q.pop_front();
          chk("out_pc", out_pc, mon_x.pc);
          chk("out_result", out_result, mon_x.result);
          chk("out_dest", 32'(out_dest), 32'(mon_x.dest));
          chk("out_gr_we", 32'(out_gr_we), 32'(mon_x.gr_we));
          chk("out_ex", 32'(out_ex), 32'(mon_x.ex));
        end
      end
      mon_nb = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (byp_valid[i]) begin
          mon_nb++;
          mon_found = 1'b0;
          foreach (snap[j])
            if (snap[j].dest == byp_dest[5*i +: 5] && snap[j].data == byp_data[32*i +: 32])
              mon_found = 1'b1;
          chk("byp_entry", 32'(mon_found), 32'd1);
        end
      end
      chk("byp_count", 32'(mon_nb), 32'(snap.size()));
    end
  end

  initial begin
    int inflight, kind;
    bit ld, st, ex;
    set_idle();
    reset  = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete(); exp_q.delete(); m_disc = 0; m_spur_next = 1'b0;
    set_expect();
    mon_en = 1'b1;
    chk("reset_byp_valid", 32'(byp_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_spurious", 32'(spurious), 32'd0);

    // Response with nothing outstanding.
    dc_data_ok = 1'b1;
    tick();
    chk("spurious_pulse", 32'(spurious), 32'd1);
    set_idle();
    tick();
    chk("spurious_clear", 32'(spurious), 32'd0);
    chk("spurious_no_entry", 32'(out_valid), 32'd0);

    load_case("lb_off3",  7'b1000000, 2'd3, 32'h80FF_0012, 32'h0, 32'hFFFF_FF80);
    load_case("lbu_off3", 7'b0100000, 2'd3, 32'h80FF_0012, 32'h0, 32'h0000_0080);
    load_case("lwl_off1", 7'b0000010, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344);
    load_case("lwr_off2", 7'b0000001, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB);
    load_case("lh_off2",  7'b0010000, 2'd2, 32'h8001_7FFF, 32'h0, 32'hFFFF_8001);

    // Fill the queue with loads while WB stalls.
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      out_ready = 1'b0;
      set_op(32'h200 + 32'(4*i), 32'h0, 32'h0, 1'b1, 1'b0, 7'b0000100, 2'd0, 1'b1, 5'(i+1), 1'b0);
      tick();
    end
    set_idle();
    out_ready = 1'b0;
    set_op(32'h2F0, 32'h5, 32'h0, 1'b0, 1'b0, 7'b0, 2'd0, 1'b1, 5'd9, 1'b0);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      out_ready  = 1'b0;
      dc_data_ok = 1'b1;
      dc_rdata   = $urandom;
      tick();
    end
    set_idle();
    set_op(32'h2F4, 32'h77, 32'h0, 1'b0, 1'b0, 7'b0, 2'd0, 1'b1, 5'd10, 1'b0);
    tick();
    set_idle();
    out_ready = 1'b0;
    #1;
    chk("swap_keeps_full", 32'(in_ready), 32'd0);
    tick();
    set_idle();
    repeat (DEPTH + 2) tick();

    // Flush with two loads in flight, then a new load.
    set_idle();
    set_op(32'h300, 32'h0, 32'h0, 1'b1, 1'b0, 7'b0000100, 2'd0, 1'b1, 5'd3, 1'b0);
    tick();
    set_op(32'h304, 32'h0, 32'h0, 1'b1, 1'b0, 7'b0000100, 2'd0, 1'b1, 5'd4, 1'b0);
    tick();
    set_idle();
    flush = 1'b1;
    tick();
    set_idle();
    set_op(32'h308, 32'h0, 32'h0, 1'b1, 1'b0, 7'b0000100, 2'd0, 1'b1, 5'd7, 1'b0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      set_idle();
      dc_data_ok = 1'b1;
      dc_rdata   = 32'h1111_1111 * 32'(i);
      tick();
      if (i < 3) chk("discard_no_output", 32'(out_valid), 32'd0);
    end
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_result", out_result, 32'h3333_3333);
    set_idle();
    tick();

    // Non-mem op behind a pending load stays in order; exception load completes alone.
    set_op(32'h400, 32'h0, 32'h0, 1'b1, 1'b0, 7'b0000100, 2'd0, 1'b1, 5'd11, 1'b0);
    tick();
    set_op(32'h404, 32'h99, 32'h0, 1'b0, 1'b0, 7'b0, 2'd0, 1'b1, 5'd12, 1'b0);
    tick();
    set_idle();
    tick();
    tick();
    chk("in_order_hold", 32'(out_valid), 32'd0);
    dc_data_ok = 1'b1;
    dc_rdata   = 32'hCAFE_F00D;
    tick();
    set_idle();
    repeat (3) tick();
    set_op(32'h500, 32'hDEAD, 32'h0, 1'b1, 1'b0, 7'b0000100, 2'd0, 1'b1, 5'd13, 1'b1);
    tick();
    set_idle();
    chk("ex_load_valid", 32'(out_valid), 32'd1);
    chk("ex_load_ex", 32'(out_ex), 32'd1);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      inflight = m_pending() + m_disc;
      set_idle();
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 49) == 0);
      dc_data_ok = (inflight > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      dc_rdata   = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        kind = $urandom_range(0, 4);
        ld = (kind < 2);
        st = (kind == 2);
        ex = ($urandom_range(0, 9) == 0);
        if ((ld || st) && !ex && inflight >= DEPTH) begin
          ld = 1'b0;
          st = 1'b0;
        end
        set_op($urandom, $urandom, $urandom, ld, st, 7'(7'b1 << $urandom_range(0, 6)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ex);
      end
      tick();
    end

    // Drain, bounded.
    for (int c = 0; c < 300; c++) begin
      set_idle();
      if (mq.size() == 0 && m_disc == 0) break;
      if (m_pending() + m_disc > 0) dc_data_ok = 1'b1;
      tick();
    end
    set_idle();
    if (mq.size() != 0 || m_disc != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d entries / %0d discards left, wanted 0", mq.size(), m_disc);
    end
    repeat (2) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
